// File: rtl/row_pool_engine.sv
// Streaming PKxPK max/average pooling engine: each PK adjacent lanes are reduced horizontally,
// then PK rows are reduced vertically through a per-{channel, segment} line buffer.
`timescale 1ns/1ps
module row_pool_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 8,
    parameter int PK         = 2,
    parameter int SEGS       = 4,
    parameter int CH         = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              mode,
    input  logic [LANES*DATA_WIDTH-1:0]       in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    output logic [(LANES/PK)*DATA_WIDTH-1:0]  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_last,
    output logic                              partial_drop
);
    localparam int LOG_PK = $clog2(PK);
    localparam int ACC_W  = DATA_WIDTH + 2*LOG_PK;
    localparam int OUT_L  = LANES / PK;
    localparam int DEPTH  = CH * SEGS;
    localparam int SEG_W  = (SEGS > 1) ? $clog2(SEGS) : 1;
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int PH_W   = LOG_PK;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGS - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PK - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                      state;
    logic [SEG_W-1:0]            seg_cnt;
    logic [CH_W-1:0]             ch_cnt;
    logic [PH_W-1:0]             phase;
    logic                        mode_q;
    logic                        accept;
    logic                        mode_eff;
    logic                        at_end;
    logic [ADDR_W-1:0]           addr;
    logic [OUT_L*ACC_W-1:0]      line_buf [DEPTH];
    logic [OUT_L*ACC_W-1:0]      entry;
    logic [OUT_L*ACC_W-1:0]      horiz;
    logic [OUT_L*ACC_W-1:0]      comb_res;
    logic [OUT_L*ACC_W-1:0]      wr_data;
    logic [OUT_L*DATA_WIDTH-1:0] out_next;
    logic signed [DATA_WIDTH-1:0] px;
    logic signed [ACC_W-1:0]     h_acc;
    logic signed [ACC_W-1:0]     lane_v;
    logic signed [ACC_W-1:0]     e_val;
    logic signed [ACC_W-1:0]     c_val;
    logic signed [ACC_W-1:0]     avg;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // The first beat of a frame uses the live mode input; later beats use the latched copy.
    assign mode_eff = (state == IDLE) ? mode : mode_q;
    assign at_end   = (seg_cnt == SEG_LAST) && (ch_cnt == CH_LAST) && (phase == PH_LAST);
    assign addr     = ADDR_W'(ch_cnt) * ADDR_W'(SEGS) + ADDR_W'(seg_cnt);
    assign entry    = line_buf[addr];
    assign wr_data  = (phase == '0) ? horiz : comb_res;

    always_comb begin
        horiz    = '0;
        comb_res = '0;
        out_next = '0;
        px       = '0;
        h_acc    = '0;
        lane_v   = '0;
        e_val    = '0;
        c_val    = '0;
        avg      = '0;
        for (int o = 0; o < OUT_L; o++) begin
            px    = in_data[(o*PK)*DATA_WIDTH +: DATA_WIDTH];
            h_acc = {{(ACC_W-DATA_WIDTH){px[DATA_WIDTH-1]}}, px};
            for (int k = 1; k < PK; k++) begin
                px     = in_data[(o*PK+k)*DATA_WIDTH +: DATA_WIDTH];
                lane_v = {{(ACC_W-DATA_WIDTH){px[DATA_WIDTH-1]}}, px};
                if (mode_eff)
                    h_acc = h_acc + lane_v;
                else if (lane_v > h_acc)
                    h_acc = lane_v;
            end
            e_val = entry[o*ACC_W +: ACC_W];
            if (mode_eff)
                c_val = e_val + h_acc;
            else
                c_val = (e_val > h_acc) ? e_val : h_acc;
            // Arithmetic shift gives floor division by the PK*PK window size.
            avg = c_val >>> (2*LOG_PK);
            horiz[o*ACC_W +: ACC_W]              = h_acc;
            comb_res[o*ACC_W +: ACC_W]           = c_val;
            out_next[o*DATA_WIDTH +: DATA_WIDTH] = mode_eff ? avg[DATA_WIDTH-1:0] : c_val[DATA_WIDTH-1:0];
        end
    end

    // Line buffer needs no reset: phase 0 always overwrites before any read.
    always_ff @(posedge clk) begin
        if (accept && (phase != PH_LAST))
            line_buf[addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            seg_cnt      <= '0;
            ch_cnt       <= '0;
            phase        <= '0;
            mode_q       <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            partial_drop <= 1'b0;
        end else begin
            partial_drop <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (accept) begin
                if (state == IDLE)
                    mode_q <= mode;
                state <= ACCUM;
                if (in_last) begin
                    state   <= IDLE;
                    seg_cnt <= '0;
                    ch_cnt  <= '0;
                    phase   <= '0;
                    if (at_end) begin
                        out_data  <= out_next;
                        out_valid <= 1'b1;
                        out_last  <= 1'b1;
                    end else begin
                        partial_drop <= 1'b1;
                    end
                end else begin
                    if (seg_cnt == SEG_LAST) begin
                        seg_cnt <= '0;
                        if (ch_cnt == CH_LAST) begin
                            ch_cnt <= '0;
                            phase  <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                        end else begin
                            ch_cnt <= ch_cnt + 1'b1;
                        end
                    end else begin
                        seg_cnt <= seg_cnt + 1'b1;
                    end
                    if (phase == PH_LAST) begin
                        out_data  <= out_next;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_row_pool_engine.sv
// Bench for row_pool_engine: directed vectors on a 2x2 single-segment instance and
// randomized frames on a 4x4 multi-channel instance checked against a window model.
`timescale 1ns/1ps
module tb_row_pool_engine;
    localparam int DW        = 8;
    localparam int B_PK      = 4;
    localparam int B_LANES   = 8;
    localparam int B_SEGS    = 2;
    localparam int B_CH      = 2;
    localparam int B_OUT     = B_LANES / B_PK;
    localparam int WIN_BEATS = B_SEGS * B_CH * B_PK;

    typedef struct { logic m; logic [31:0] r0; logic [31:0] r1; logic [15:0] exp; } vec_t;
    typedef struct { logic [15:0] data; logic last; int cyc; } obs_t;
    typedef struct { logic [15:0] data; logic last; } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_mode, a_in_valid, a_in_ready, a_in_last;
    logic [31:0] a_in_data;
    logic [15:0] a_out_data;
    logic        a_out_valid, a_out_ready, a_out_last, a_partial_drop;
    logic        b_mode, b_in_valid, b_in_ready, b_in_last;
    logic [63:0] b_in_data;
    logic [15:0] b_out_data;
    logic        b_out_valid, b_out_ready, b_out_last, b_partial_drop;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   a_drops = 0;
    int   b_drops = 0;
    int   b_drops_exp = 0;
    logic b_rand = 1'b0;
    logic b_hold = 1'b0;
    obs_t a_log[$];
    exp_t b_exp[$];
    int   win [B_PK][B_CH][B_SEGS][B_LANES];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    row_pool_engine #(.DATA_WIDTH(8), .LANES(4), .PK(2), .SEGS(1), .CH(1)) dut_a (
        .clk(clk), .rstn(rstn), .mode(a_mode), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_last(a_in_last), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_last(a_out_last), .partial_drop(a_partial_drop));

    row_pool_engine #(.DATA_WIDTH(8), .LANES(B_LANES), .PK(B_PK), .SEGS(B_SEGS), .CH(B_CH)) dut_b (
        .clk(clk), .rstn(rstn), .mode(b_mode), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_last(b_in_last), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_last(b_out_last), .partial_drop(b_partial_drop));

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int p0, input int p1, input int p2, input int p3);
        logic [31:0] v;
        v = {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
        return v;
    endfunction

    function automatic logic [15:0] pack2(input int p0, input int p1);
        logic [15:0] v;
        v = {p1[7:0], p0[7:0]};
        return v;
    endfunction

    // Pool one full PKxPK window per output lane straight from the stored pixels.
    function automatic logic [15:0] pool_expect(input int ch, input int seg, input logic m);
        logic [15:0] res;
        int acc;
        int v;
        res = '0;
        for (int o = 0; o < B_OUT; o++) begin
            acc = m ? 0 : -129;
            for (int r = 0; r < B_PK; r++)
                for (int k = 0; k < B_PK; k++) begin
                    v = win[r][ch][seg][o*B_PK+k];
                    if (m) acc += v;
                    else if (v > acc) acc = v;
                end
            if (m) begin
                if (acc < 0 && (acc % (B_PK*B_PK)) != 0) acc = acc / (B_PK*B_PK) - 1;
                else acc = acc / (B_PK*B_PK);
            end
            res[o*DW +: DW] = acc[7:0];
        end
        return res;
    endfunction

    // Drive one beat into dut_a and hold it until accepted; returns the accept cycle.
    task automatic apply_stimulus(input logic [31:0] d, input logic last, input logic m, output int acc_cyc);
        a_in_data  = d;
        a_in_last  = last;
        a_mode     = m;
        a_in_valid = 1'b1;
        acc_cyc    = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                acc_cyc = cyc;
                break;
            end
        end
        if (acc_cyc < 0) check_output("a_accept_timeout", 0, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic expect_one(input string name, input logic [15:0] exp, input logic last, input int acc_cyc);
        check_output({name, "_count"}, a_log.size(), 1);
        if (a_log.size() > 0) begin
            check_output({name, "_data"}, a_log[0].data, exp);
            check_output({name, "_last"}, a_log[0].last, last);
            check_output({name, "_latency"}, a_log[0].cyc, acc_cyc + 1);
        end
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_output({name, "_out_valid"}, a_out_valid, 0);
        check_output({name, "_out_data"}, a_out_data, 0);
        check_output({name, "_out_last"}, a_out_last, 0);
        check_output({name, "_partial_drop"}, a_partial_drop, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic run_frame_b(input int nbeats, input logic fm);
        for (int b = 0; b < nbeats; b++) begin
            logic [63:0] d;
            int seg, ch, ph, px;
            int pix [B_LANES];
            logic last;
            bit got;
            seg  = b % B_SEGS;
            ch   = (b / B_SEGS) % B_CH;
            ph   = (b / (B_SEGS*B_CH)) % B_PK;
            last = (b == nbeats - 1);
            d    = '0;
            for (int l = 0; l < B_LANES; l++) begin
                px = int'($urandom_range(0, 255)) - 128;
                d[l*DW +: DW] = px[7:0];
                pix[l] = px;
            end
            b_in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            b_in_data  = d;
            b_in_last  = last;
            b_mode     = (b == 0) ? fm : 1'($urandom_range(0, 1));
            b_in_valid = 1'b1;
            got = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (b_in_ready) begin got = 1; break; end
            end
            if (!got) check_output("b_accept_timeout", 0, 1);
            else begin
                for (int l = 0; l < B_LANES; l++) win[ph][ch][seg][l] = pix[l];
                if (last && !(seg == B_SEGS-1 && ch == B_CH-1 && ph == B_PK-1)) b_drops_exp++;
                else if (ph == B_PK-1) b_exp.push_back('{pool_expect(ch, seg, fm), last});
            end
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            b_in_last  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) a_log.push_back('{a_out_data, a_out_last, cyc});
        if (a_partial_drop) a_drops++;
    end

    // Output of dut_b must always show the oldest unconsumed model result.
    always @(negedge clk) begin
        if (b_hold) check_output("b_valid_held", b_out_valid, 1);
        if (b_out_valid) begin
            if (b_exp.size() == 0) check_output("b_spurious_valid", b_out_valid, 0);
            else begin
                check_output("b_out_data", b_out_data, b_exp[0].data);
                if (b_out_ready) begin
                    check_output("b_out_last", b_out_last, b_exp[0].last);
                    void'(b_exp.pop_front());
                end
            end
        end
        if (b_partial_drop) b_drops++;
        b_hold = rstn && b_out_valid && !b_out_ready;
    end

    always @(posedge clk) begin
        #1;
        b_out_ready = b_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial begin
        int acc [4];
        int t;
        int d0;
        vec_t vecs [7];
        logic [31:0] ra, rb, rc, rd;

        ra = pack4(1, 5, -3, 2);
        rb = pack4(4, 0, 7, -8);
        rc = pack4(10, 20, 30, 40);
        rd = pack4(-1, -2, -3, -4);
        vecs[0] = '{1'b0, ra, rb, pack2(5, 7)};
        vecs[1] = '{1'b1, ra, rb, pack2(2, -1)};
        vecs[2] = '{1'b0, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -127), pack2(-128, -127)};
        vecs[3] = '{1'b1, pack4(127, 127, 127, 127), pack4(127, 127, 127, 127), pack2(127, 127)};
        vecs[4] = '{1'b1, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), pack2(-128, -128)};
        vecs[5] = '{1'b1, pack4(-1, 0, 0, 0), pack4(0, 0, 3, 0), pack2(-1, 0)};
        vecs[6] = '{1'b0, pack4(-5, -6, -7, -8), pack4(-9, -10, -2, -3), pack2(-5, -2)};

        rstn = 1'b0;
        a_mode = 0; a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_out_ready = 1'b1;
        b_mode = 0; b_in_valid = 0; b_in_last = 0; b_in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid", a_out_valid, 0);
        check_output("rst_out_data", a_out_data, 0);
        check_output("rst_out_last", a_out_last, 0);
        check_output("rst_partial_drop", a_partial_drop, 0);
        check_output("rst_b_out_valid", b_out_valid, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check_output("rst_in_ready", a_in_ready, 1);
        @(posedge clk); #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 7; i++) begin
            a_log.delete();
            apply_stimulus(vecs[i].r0, 1'b0, vecs[i].m, acc[0]);
            apply_stimulus(vecs[i].r1, 1'b1, vecs[i].m, acc[1]);
            repeat (3) @(posedge clk); #1;
            expect_one($sformatf("vec%0d", i), vecs[i].exp, 1'b1, acc[1]);
        end

        $display("[TB] backpressure hold");
        a_log.delete();
        a_out_ready = 1'b0;
        apply_stimulus(ra, 1'b0, 1'b0, acc[0]);
        apply_stimulus(rb, 1'b1, 1'b0, acc[1]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_in_ready", a_in_ready, 0);
            check_output("bp_out_valid", a_out_valid, 1);
            check_output("bp_out_data", a_out_data, pack2(5, 7));
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_output("bp_count", a_log.size(), 1);
        if (a_log.size() > 0) check_output("bp_data", a_log[0].data, pack2(5, 7));

        $display("[TB] continuous streaming");
        a_log.delete();
        apply_stimulus(ra, 1'b0, 1'b0, acc[0]);
        apply_stimulus(rb, 1'b0, 1'b0, acc[1]);
        apply_stimulus(rc, 1'b0, 1'b0, acc[2]);
        apply_stimulus(rd, 1'b1, 1'b0, acc[3]);
        repeat (3) @(posedge clk); #1;
        check_output("stream_no_gap", acc[3] - acc[0], 3);
        check_output("stream_count", a_log.size(), 2);
        if (a_log.size() == 2) begin
            check_output("stream_d0", a_log[0].data, pack2(5, 7));
            check_output("stream_l0", a_log[0].last, 0);
            check_output("stream_d1", a_log[1].data, pack2(20, 40));
            check_output("stream_l1", a_log[1].last, 1);
            check_output("stream_spacing", a_log[1].cyc - a_log[0].cyc, 2);
        end

        $display("[TB] partial frame");
        a_log.delete();
        d0 = a_drops;
        apply_stimulus(ra, 1'b1, 1'b0, acc[0]);
        repeat (3) @(posedge clk); #1;
        check_output("partial_no_out", a_log.size(), 0);
        check_output("partial_pulse", a_drops - d0, 1);
        apply_stimulus(ra, 1'b0, 1'b0, acc[0]);
        apply_stimulus(rb, 1'b1, 1'b0, acc[1]);
        repeat (3) @(posedge clk); #1;
        expect_one("after_partial", pack2(5, 7), 1'b1, acc[1]);

        $display("[TB] mode change mid frame");
        a_log.delete();
        apply_stimulus(ra, 1'b0, 1'b0, acc[0]);
        apply_stimulus(rb, 1'b1, 1'b1, acc[1]);
        repeat (3) @(posedge clk); #1;
        expect_one("mode_keep_max", pack2(5, 7), 1'b1, acc[1]);
        a_log.delete();
        apply_stimulus(ra, 1'b0, 1'b1, acc[0]);
        apply_stimulus(rb, 1'b1, 1'b0, acc[1]);
        repeat (3) @(posedge clk); #1;
        expect_one("mode_keep_avg", pack2(2, -1), 1'b1, acc[1]);

        $display("[TB] reset with pending output and mid frame");
        a_out_ready = 1'b0;
        apply_stimulus(ra, 1'b0, 1'b0, acc[0]);
        apply_stimulus(rb, 1'b0, 1'b0, acc[1]);
        pulse_reset("rst_pending");
        a_out_ready = 1'b1;
        a_log.delete();
        apply_stimulus(pack4(100, 100, 100, 100), 1'b0, 1'b1, acc[0]);
        pulse_reset("rst_midframe");
        a_log.delete();
        apply_stimulus(ra, 1'b0, 1'b0, acc[0]);
        @(negedge clk);
        check_output("rst_first_row_no_out", a_out_valid, 0);
        @(posedge clk); #1;
        apply_stimulus(rb, 1'b1, 1'b0, acc[1]);
        repeat (3) @(posedge clk); #1;
        expect_one("after_reset", pack2(5, 7), 1'b1, acc[1]);

        $display("[TB] randomized frames against window model");
        b_rand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            logic fm;
            int nb;
            fm = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 2*WIN_BEATS - 1);
            else nb = WIN_BEATS * $urandom_range(1, 3);
            run_frame_b(nb, fm);
        end
        b_rand = 1'b0;
        t = 0;
        while (b_exp.size() != 0 && t < 1000) begin
            @(posedge clk);
            t++;
        end
        repeat (5) @(posedge clk); #1;
        check_output("b_drain_empty", b_exp.size(), 0);
        check_output("b_drop_count", b_drops, b_drops_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
